// File: rtl/func_sweep_checker.sv
// ---------------------------------------------------------------------------
// func_sweep_checker
//
// On-board self-test sequencer for the 4-bit prime / divisible-by-3
// classifier. After a start request it drives every code 0..15 in ascending
// order on a_out. Each code is held for SETTLE cycles and then sampled for
// one cycle. The returned p/d flags are compared with the expected truth
// masks. The block accumulates an error count and latches the lowest failing
// code, then raises done and pass.
//
// Parameters
//   SETTLE      cycles a_out is held before sampling (legal 1..15)
//   EXP_P_MASK  bit k = expected p flag for code k
//   EXP_D_MASK  bit k = expected d flag for code k
//
// Ports
//   clk              in   system clock, rising-edge active
//   rst              in   asynchronous active-high reset
//   start            in   begin a sweep (honoured only when idle or done)
//   a_out            out  code driven to the classifier input
//   p_in, d_in       in   classifier flags (combinational return of a_out)
//   busy             out  sweep in progress
//   done             out  sweep complete; results valid
//   pass             out  done with zero mismatches
//   err_count        out  number of codes with any mismatch (0..16)
//   first_err_valid  out  a mismatch has been captured this sweep
//   first_err_code   out  lowest mismatching code
// ---------------------------------------------------------------------------
module func_sweep_checker #(
    parameter int          SETTLE     = 2,
    parameter logic [15:0] EXP_P_MASK = 16'h28AC,
    parameter logic [15:0] EXP_D_MASK = 16'h9249
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [3:0] a_out,
    input  logic       p_in,
    input  logic       d_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic       first_err_valid,
    output logic [3:0] first_err_code
);

    // Out-of-range SETTLE values are clamped into 1..15, so the 4-bit settle
    // counter can always reach its terminal value.
    localparam int         SETTLE_C = (SETTLE < 1) ? 1 : ((SETTLE > 15) ? 15 : SETTLE);
    localparam logic [3:0] LAST_CNT = 4'(SETTLE_C - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] a_q, a_d;
    logic [3:0] cnt_q, cnt_d;
    logic [4:0] err_q, err_d;
    logic       fev_q, fev_d;
    logic [3:0] fec_q, fec_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;

    logic       settle_done;
    logic       last_code;
    logic       mismatch;
    logic [4:0] err_total;

    assign settle_done = (cnt_q == LAST_CNT);
    assign last_code   = (a_q == 4'hF);

    // A code that is wrong on both flags still counts as a single error.
    assign mismatch  = (p_in != EXP_P_MASK[a_q]) | (d_in != EXP_D_MASK[a_q]);
    // The count including the sample being taken now. pass uses it on the
    // final code, so a mismatch on code 15 is not missed.
    assign err_total = err_q + 5'(mismatch);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (settle_done) begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                state_d = last_code ? S_DONE : S_DRIVE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        a_d    = a_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        fev_d  = fev_q;
        fec_d  = fec_q;
        busy_d = busy_q;
        done_d = done_q;
        pass_d = pass_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                // Results from the previous sweep are held until a restart.
                if (start) begin
                    a_d    = 4'd0;
                    cnt_d  = 4'd0;
                    err_d  = 5'd0;
                    fev_d  = 1'b0;
                    fec_d  = 4'd0;
                    busy_d = 1'b1;
                    done_d = 1'b0;
                    pass_d = 1'b0;
                end
            end
            S_DRIVE: begin
                // The counter stops at its terminal value. The sample state
                // clears it before the next code is driven.
                if (!settle_done) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_SAMPLE: begin
                if (mismatch) begin
                    err_d = err_total;
                    if (!fev_q) begin
                        fev_d = 1'b1;
                        fec_d = a_q;
                    end
                end
                if (last_code) begin
                    // a_out stays at 15 once the sweep is finished.
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    pass_d = (err_total == 5'd0);
                end else begin
                    a_d   = a_q + 4'd1;
                    cnt_d = 4'd0;
                end
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= 4'd0;
            cnt_q  <= 4'd0;
            err_q  <= 5'd0;
            fev_q  <= 1'b0;
            fec_q  <= 4'd0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
            fev_q  <= fev_d;
            fec_q  <= fec_d;
            busy_q <= busy_d;
            done_q <= done_d;
            pass_q <= pass_d;
        end
    end

    assign a_out           = a_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign first_err_valid = fev_q;
    assign first_err_code  = fec_q;

endmodule

// File: doc/func_sweep_checker.md
Name: func_sweep_checker

Overview:
- Hardware sweep and response checker for the 4-bit classifier block (input code a, flag outputs p and d).
- Drives every code 0..15 in ascending order onto the classifier and waits a programmable settle time after each code.
- Samples the returned p/d flags and compares them against expected truth masks.
- Reports pass/fail, error count and first failing code. Used for on-board self-test of the classifier.

Parameters:
- SETTLE, 2: cycles a_out is held before sampling; legal range 1..15.
- EXP_P_MASK, 16'h28AC: bit k = expected p for code k (primes 2,3,5,7,11,13).
- EXP_D_MASK, 16'h9249: bit k = expected d for code k (multiples of 3: 0,3,6,9,12,15).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin sweep; sampled only in IDLE or DONE.
- a_out  out  4  code driven to the classifier input a.
- p_in  in  1  classifier p flag; combinational return.
- d_in  in  1  classifier d flag; combinational return.
- busy  out  1  high while a sweep is running.
- done  out  1  high from sweep completion until the next accepted start.
- pass  out  1  valid when done=1; 1 iff err_count==0.
- err_count  out  5  number of codes with any p or d mismatch (0..16).
- first_err_valid  out  1  a mismatch has been captured this sweep.
- first_err_code  out  4  lowest code that mismatched; valid when first_err_valid=1.

Behaviour:
- Reset (async, active-high): state=IDLE. a_out=0, busy=0, done=0, pass=0, err_count=0, first_err_valid=0, first_err_code=0, settle counter=0.
- Reset asserted mid-sweep aborts the sweep immediately to these values. No partial result is retained.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE or DONE with start=1:
  - a_out<=0, cnt<=0, err_count<=0, first_err_valid<=0, first_err_code<=0.
  - done<=0, pass<=0, busy<=1, go to DRIVE.
- DRIVE:
  - If cnt==SETTLE-1, go to SAMPLE.
  - Otherwise cnt<=cnt+1.
  - a_out is stable throughout.
- SAMPLE (one cycle): mismatch = (p_in != EXP_P_MASK[a_out]) | (d_in != EXP_D_MASK[a_out]).
  - On mismatch: err_count<=err_count+1. If first_err_valid==0, latch first_err_code<=a_out and set first_err_valid<=1.
  - A code with both p and d wrong counts as one error.
  - If a_out==15: go to DONE. busy<=0, done<=1, pass<=(final err_count==0), including this cycle's mismatch.
  - Otherwise: a_out<=a_out+1, cnt<=0, go to DRIVE. No wrap past 15.
- DONE:
  - All results hold; a_out stays at 15.
  - start restarts the sweep (same actions as IDLE start).
- start is ignored while busy=1.
- Latency: each code takes SETTLE+1 cycles. done rises 16*(SETTLE+1) rising edges after the edge that accepted start (48 for SETTLE=2).
- err_count is 5 bits so the maximum value 16 cannot overflow; no saturation logic is needed.

Test Plan:
- Golden classifier model (prime/div-3), SETTLE=2, pulse start:
  - a_out steps 0..15, each code held 3 cycles.
  - done=1 exactly 48 edges after start; pass=1, err_count=0, first_err_valid=0.
- p_in tied 0, d_in correct:
  - done with pass=0, err_count=6, first_err_valid=1, first_err_code=2.
- d_in inverted, p_in correct:
  - err_count=16, first_err_code=0, pass=0.
- Both p_in and d_in wrong on code 5 only:
  - err_count=1, first_err_code=5.
- start held high for the whole run:
  - No restart before done; done at edge 48.
  - A start pulse while done=1 clears done/err_count next edge, a_out=0, busy=1.
- rst asserted at edge 20 mid-sweep:
  - All outputs return to reset values without waiting for a clock.
  - A later start produces a full 48-cycle sweep with pass=1. Rerun with SETTLE=1: done after 32 edges.
